// File: rtl/l1an_readout_ctrl_if.sv
// FIFO-side and readout-side handshake signals of the L1A-number readout controller.
interface l1an_readout_ctrl_if;
  logic       FIFO_EMPTY;
  logic [5:0] L1ANUM_IN;
  logic       PHASE_IN;
  logic       FIFO_POP;
  logic       RDY_IN;
  logic       EVT_START;
  logic [5:0] L1ANUM_OUT;
  logic       PHASE_OUT;
  logic       WORD_RD;
  logic [6:0] WORD_CNT;
  logic       EVT_DONE;

  modport master (
    input  FIFO_EMPTY, L1ANUM_IN, PHASE_IN, RDY_IN,
    output FIFO_POP, EVT_START, L1ANUM_OUT, PHASE_OUT, WORD_RD, WORD_CNT, EVT_DONE
  );

  modport slave (
    output FIFO_EMPTY, L1ANUM_IN, PHASE_IN, RDY_IN,
    input  FIFO_POP, EVT_START, L1ANUM_OUT, PHASE_OUT, WORD_RD, WORD_CNT, EVT_DONE
  );
endinterface

// File: rtl/l1an_readout_ctrl.sv
// Pops one L1A number per event, emits header/data/trailer strobes, and aborts on stall timeout.
// Optional triplication votes every register; all outputs decode from the voted copy.
module l1an_readout_ctrl #(
  parameter int TMR    = 0,
  parameter int NWORDS = 96,
  parameter int TMO    = 255
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ENABLE,
  input  logic                 ERR_CLR,
  l1an_readout_ctrl_if.master  bus,
  output logic                 BUSY,
  output logic                 TMO_ERR,
  output logic [11:0]          EVT_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LATCH  = 3'd2,
    ST_HDR    = 3'd3,
    ST_XFER   = 3'd4,
    ST_TRLR   = 3'd5
  } state_t;

  typedef struct packed {
    state_t      st;
    logic        hdr_first;
    logic [6:0]  wcnt;
    logic [7:0]  scnt;
    logic [11:0] ecnt;
    logic        tmo;
    logic [5:0]  l1a;
    logic        ph;
  } regs_t;

  localparam int         NCOPY     = (TMR != 0) ? 3 : 1;
  localparam int         RW        = $bits(regs_t);
  localparam logic [6:0] LAST_WORD = 7'(NWORDS - 1);
  localparam logic [7:0] TMO_LAST  = 8'(TMO - 1);
  localparam regs_t      REGS_RST  = regs_t'({RW{1'b0}});

  function automatic logic [RW-1:0] maj3(input logic [RW-1:0] a,
                                         input logic [RW-1:0] b,
                                         input logic [RW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  regs_t regs_r [NCOPY];
  regs_t cur_s;
  regs_t nxt_s;
  logic  timeout_s;

  if (NCOPY == 3) begin : g_vote
    assign cur_s = regs_t'(maj3(regs_r[0], regs_r[1], regs_r[2]));
  end else begin : g_single
    assign cur_s = regs_r[0];
  end

  // State/counter register copies, all reloaded from the voted next value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NCOPY; i++) regs_r[i] <= REGS_RST;
    end else begin
      for (int i = 0; i < NCOPY; i++) regs_r[i] <= nxt_s;
    end
  end

  // Next-state, counters, latch and sticky-error update.
  always_comb begin
    nxt_s           = cur_s;
    nxt_s.hdr_first = 1'b0;
    timeout_s       = 1'b0;

    case (cur_s.st)
      ST_IDLE: begin
        if (ENABLE && !bus.FIFO_EMPTY) nxt_s.st = ST_SETTLE;
        else                           nxt_s.st = ST_IDLE;
      end
      ST_SETTLE: nxt_s.st = ST_LATCH;
      ST_LATCH: begin
        nxt_s.st        = ST_HDR;
        nxt_s.l1a       = bus.L1ANUM_IN;
        nxt_s.ph        = bus.PHASE_IN;
        nxt_s.wcnt      = 7'd0;
        nxt_s.hdr_first = 1'b1;
      end
      ST_HDR: begin
        if (bus.RDY_IN) nxt_s.st = ST_XFER;
        else            nxt_s.st = ST_HDR;
      end
      ST_XFER: begin
        if (bus.RDY_IN) begin
          nxt_s.wcnt = cur_s.wcnt + 7'd1;
          if (cur_s.wcnt == LAST_WORD) nxt_s.st = ST_TRLR;
          else                         nxt_s.st = ST_XFER;
        end else begin
          nxt_s.st = ST_XFER;
        end
      end
      ST_TRLR: begin
        nxt_s.st   = ST_IDLE;
        nxt_s.ecnt = cur_s.ecnt + 12'd1;
      end
      default: nxt_s.st = ST_IDLE;
    endcase

    // Stall run length only grows while waiting on the downstream side.
    if ((cur_s.st == ST_HDR || cur_s.st == ST_XFER) && !bus.RDY_IN) begin
      if (cur_s.scnt == TMO_LAST) begin
        timeout_s  = 1'b1;
        nxt_s.st   = ST_IDLE;
        nxt_s.scnt = 8'd0;
      end else begin
        nxt_s.scnt = cur_s.scnt + 8'd1;
      end
    end else begin
      nxt_s.scnt = 8'd0;
    end

    if (timeout_s)    nxt_s.tmo = 1'b1;
    else if (ERR_CLR) nxt_s.tmo = 1'b0;
    else              nxt_s.tmo = cur_s.tmo;
  end

  assign bus.FIFO_POP   = (cur_s.st == ST_LATCH);
  assign bus.EVT_START  = (cur_s.st == ST_HDR) && cur_s.hdr_first;
  assign bus.L1ANUM_OUT = cur_s.l1a;
  assign bus.PHASE_OUT  = cur_s.ph;
  assign bus.WORD_RD    = (cur_s.st == ST_XFER) && bus.RDY_IN;
  assign bus.WORD_CNT   = cur_s.wcnt;
  assign bus.EVT_DONE   = (cur_s.st == ST_TRLR);
  assign BUSY           = (cur_s.st != ST_IDLE);
  assign TMO_ERR        = cur_s.tmo;
  assign EVT_CNT        = cur_s.ecnt;

endmodule

// File: doc/l1an_readout_ctrl.md
L1AN_READOUT_CTRL -- requirements
Module: l1an_readout_ctrl

Interface
REQ-001 Parameter TMR, default 0; 1 = triplicated state/counter registers with majority vote on every registered output.
REQ-002 Parameter NWORDS, default 96; data words per event (legal 1..127).
REQ-003 Parameter TMO, default 255; stall-timeout limit in cycles (legal 1..255).
REQ-004 CLK  in  1  single clock, all logic on rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 ENABLE  in  1  high = new events may be started.
REQ-007 FIFO_EMPTY  in  1  L1A-number FIFO empty flag.
REQ-008 L1ANUM_IN  in  6  FIFO head L1A number (registered RAM output).
REQ-009 PHASE_IN  in  1  FIFO head L1A phase.
REQ-010 RDY_IN  in  1  downstream ready, one word accepted per cycle while high.
REQ-011 ERR_CLR  in  1  synchronous clear of TMO_ERR.
REQ-012 FIFO_POP  out  1  one-cycle pop strobe to the FIFO.
REQ-013 EVT_START  out  1  one-cycle pulse, event header phase begins.
REQ-014 L1ANUM_OUT  out  6  latched L1A number of current event.
REQ-015 PHASE_OUT  out  1  latched phase of current event.
REQ-016 WORD_RD  out  1  read strobe, one per transferred data word.
REQ-017 WORD_CNT  out  7  words transferred in current event.
REQ-018 EVT_DONE  out  1  one-cycle pulse, event completed normally.
REQ-019 BUSY  out  1  high in every state except IDLE.
REQ-020 TMO_ERR  out  1  sticky timeout flag.
REQ-021 EVT_CNT  out  12  completed-event counter, wraps 4095->0.

Function
REQ-022 States: IDLE, SETTLE, LATCH, HDR, XFER, TRLR; encoding free, one state active.
REQ-023 IDLE->SETTLE when ENABLE=1 and FIFO_EMPTY=0; else hold IDLE.
REQ-024 SETTLE: one cycle, lets RAM output reflect head entry; ->LATCH unconditionally.
REQ-025 LATCH: one cycle; L1ANUM_OUT/PHASE_OUT capture L1ANUM_IN/PHASE_IN at end of cycle; FIFO_POP=1 this cycle only; WORD_CNT cleared; ->HDR.
REQ-026 HDR: EVT_START=1 on first HDR cycle only; stay until RDY_IN=1, then ->XFER.
REQ-027 XFER: WORD_RD = RDY_IN (combinational in state); WORD_CNT increments per WORD_RD; on WORD_RD with WORD_CNT=NWORDS-1 ->TRLR.
REQ-028 TRLR: one cycle; EVT_DONE=1; EVT_CNT+1; ->IDLE.
REQ-029 Minimum event latency, FIFO_EMPTY fall to EVT_DONE with RDY_IN held high: NWORDS+4 cycles.
REQ-030 Back-to-back: IDLE re-evaluates FIFO_EMPTY the cycle after TRLR; no pop issued while FIFO_EMPTY=1.
REQ-031 FIFO_POP never asserted outside LATCH; exactly one pop per started event, including aborted events.
REQ-032 ENABLE falling mid-event: current event runs to TRLR or timeout; no new event started.
REQ-033 Stall counter: in HDR/XFER counts consecutive cycles with RDY_IN=0, cleared when RDY_IN=1 or state change.
REQ-034 Stall count reaching TMO: ->IDLE next cycle, TMO_ERR=1, no EVT_DONE, EVT_CNT unchanged.
REQ-035 TMO_ERR cleared only by ERR_CLR=1 or reset; a timeout coinciding with ERR_CLR leaves TMO_ERR=1.
REQ-036 L1ANUM_OUT/PHASE_OUT hold value until next LATCH.

Reset
REQ-037 RST_N=0 forces immediately: state IDLE, FIFO_POP/EVT_START/WORD_RD/EVT_DONE/BUSY/TMO_ERR=0, L1ANUM_OUT=0, PHASE_OUT=0, WORD_CNT=0, EVT_CNT=0, stall count 0.
REQ-038 Reset mid-event abandons event with no further strobes; the popped entry is not replayed.
REQ-039 First state evaluation at first rising edge after RST_N deasserts.

Verification
REQ-040 Single event: FIFO holds L1A 0x2A phase 1, RDY_IN=1 -> one FIFO_POP, EVT_START, 96 WORD_RD, EVT_DONE at cycle 100 after FIFO_EMPTY fall, L1ANUM_OUT=0x2A, PHASE_OUT=1, EVT_CNT=1.
REQ-041 Three queued entries 0x01,0x02,0x03 -> three sequential events in order, no gaps beyond IDLE/SETTLE/LATCH, EVT_CNT=3, exactly 3 pops.
REQ-042 RDY_IN toggled 50% in XFER -> WORD_RD only on RDY_IN=1 cycles, WORD_CNT reaches 96, no timeout.
REQ-043 RDY_IN held 0 in HDR -> after 255 cycles return to IDLE, TMO_ERR=1, EVT_DONE never pulses; ERR_CLR pulse -> TMO_ERR=0.
REQ-044 ENABLE dropped at word 10 with FIFO non-empty -> event completes, BUSY falls, no further pop until ENABLE=1.
REQ-045 RST_N pulsed low in XFER at word 40 -> all outputs zero asynchronously, FIFO_POP absent, next event starts with WORD_CNT=0.
